// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the command UART link.
package uart_pkg;

    // 50 MHz system clock at 19200 baud.
    localparam int unsigned BAUD_DIV_DEF = 2604;
    // Start + 8 data + stop.
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic {RxIdle, RxRecv} rx_state_e;
    typedef enum logic {TxIdle, TxXmit} tx_state_e;
    typedef enum logic {AsmHigh, AsmLow} asm_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: synchronises RX, finds the start edge, samples mid-bit and
// emits a one-cycle rx_rdy with the received byte on a good stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       rx_rdy,
    output logic [7:0] rx_data
);

    localparam int unsigned CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    logic          sync1_q, rx_s, rx_prev_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          rdy_q, rdy_d;

    // Synchroniser, edge-detect history and receiver state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RxIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rdy_q     <= 1'b0;
        end else begin
            sync1_q   <= RX;
            rx_s      <= sync1_q;
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rdy_q     <= rdy_d;
        end
    end

    // Sample 0 lands mid start bit; samples 1..8 are data, sample 9 is stop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rdy_d   = 1'b0;
        unique case (state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_s) begin
                    state_d = RxRecv;
                    cnt_d   = CNT_HALF;
                    bit_d   = '0;
                end
            end
            RxRecv: begin
                if (cnt_q == CW'(1)) begin
                    cnt_d = CNT_FULL;
                    bit_d = bit_q + 4'd1;
                    if (bit_q == LAST_BIT) begin
                        // A low stop bit is a framing error: drop the byte.
                        state_d = RxIdle;
                        rdy_d   = rx_s;
                    end else if (bit_q != 4'd0) begin
                        shift_d = {rx_s, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    assign rx_rdy  = rdy_q;
    assign rx_data = shift_q;

endmodule

// File: rtl/cmd_uart_wrapper.sv
// Knight-side link end: pairs received bytes into 16-bit commands and
// serialises 8-bit responses back to the remote.
module cmd_uart_wrapper
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int unsigned CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    logic       rx_rdy;
    logic [7:0] rx_data;

    uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .rx_rdy  (rx_rdy),
        .rx_data (rx_data)
    );

    asm_state_e    asm_q, asm_d;
    logic [7:0]    cmd_hi_q, cmd_hi_d;
    logic [15:0]   cmd_q, cmd_d;
    logic          cmd_rdy_q, cmd_rdy_d;

    tx_state_e     tx_state_q, tx_state_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic          tx_done_q, tx_done_d;

    // Assembly and transmitter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q      <= AsmHigh;
            cmd_hi_q   <= '0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            tx_state_q <= TxIdle;
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            cmd_hi_q   <= cmd_hi_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // Byte pairing: high byte first, low byte completes the command.
    always_comb begin
        asm_d     = asm_q;
        cmd_hi_d  = cmd_hi_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        // Captures come after the clear so a coincident LOW capture wins.
        if (rx_rdy) begin
            unique case (asm_q)
                AsmHigh: begin
                    cmd_hi_d  = rx_data;
                    cmd_rdy_d = 1'b0;
                    asm_d     = AsmLow;
                end
                AsmLow: begin
                    cmd_d     = {cmd_hi_q, rx_data};
                    cmd_rdy_d = 1'b1;
                    asm_d     = AsmHigh;
                end
                default: asm_d = AsmHigh;
            endcase
        end
    end

    // Transmitter: load frame on trmt, shift one bit every BAUD_DIV cycles.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_done_d  = tx_done_q;
        unique case (tx_state_q)
            TxIdle: begin
                if (trmt) begin
                    tx_shift_d = {1'b1, resp, 1'b0};
                    tx_done_d  = 1'b0;
                    tx_cnt_d   = CNT_FULL;
                    tx_bit_d   = '0;
                    tx_state_d = TxXmit;
                end
            end
            TxXmit: begin
                if (tx_cnt_q == CW'(1)) begin
                    tx_cnt_d   = CNT_FULL;
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = TxIdle;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    assign TX      = (tx_state_q == TxXmit) ? tx_shift_q[0] : 1'b1;
    assign tx_done = tx_done_q;
    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

endmodule
